mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory-bus port of the address interpreter (ren/wen/ack with a 4-phase drop) among NUM_REQ masters:
//  CPU I-fetch, CPU data, DMA. Latches the winner's command, runs one full handshake downstream, returns read data + ack pulse.
//  Sits between requesters and address interpreter; one transaction in flight at a time.
// PARAMETERS
//  NUM_REQ   3   number of requesters; index 0 = highest fixed priority
//  AW        32  address width
//  DW        32  data width
// PORTS
//  clk          in   1            system clock; all logic rising-edge
//  rst          in   1            asynchronous, active-high reset
//  req_addr     in   NUM_REQ*AW   flattened per-requester byte address, slice i = [i*AW +: AW]
//  req_data_i   in   NUM_REQ*DW   flattened per-requester write data
//  req_ren      in   NUM_REQ      read request, level, held until own ack
//  req_wen      in   NUM_REQ      write request, level, held until own ack
//  req_ack      out  NUM_REQ      one-cycle completion pulse to granted requester
//  req_data_o   out  DW           read data, shared by all requesters; valid only in the ack cycle
//  m_addr       out  AW           to address interpreter addr
//  m_data_i     out  DW           to address interpreter data_i
//  m_ren        out  1            to address interpreter ren
//  m_wen        out  1            to address interpreter wen
//  m_ack        in   1            from address interpreter ack; level, falls after ren/wen fall
//  m_data_o     in   DW           from address interpreter data_o
//  gnt          out  NUM_REQ      one-hot current owner; 0 when idle (debug/perf)
// BEHAVIOUR
//  Reset values: every output is 0, state = IDLE, priority pointer = 0.
//  FSM states: IDLE, ISSUE, RELEASE. All outputs are registered.
//  IDLE
//   - A requester is active when req_ren[i] | req_wen[i].
//   - If any requester is active: select winner; latch its addr, data_i, ren, wen; set gnt; go to ISSUE.
//   - m_ren/m_wen rise one cycle after the request is sampled.
//   - If req_ren and req_wen are both set: read wins, wen is dropped.
//  ISSUE
//   - Hold m_* stable from the latched values. Requester inputs are ignored.
//   - On m_ack = 1: capture m_data_o into req_data_o, pulse req_ack[winner] next cycle, clear m_ren/m_wen same edge,
//     go to RELEASE.
//   - The cycle after the pulse, req_ack returns to 0.
//  RELEASE
//   - Wait for m_ack = 0, then clear gnt and go to IDLE.
//   - The interpreter WAIT state demands this; never issue while m_ack is high.
//  Latency: best case request-to-ack = 1 (latch) + interpreter latency + 1 (pulse).
//   - Minimum 2 idle cycles between back-to-back grants (RELEASE -> IDLE -> ISSUE).
//  Requester drops its request mid-transaction: the transaction still completes and the ack still pulses.
//   - The requester discards the pulse; no abort.
//  Requester keeps its request high after ack: treated as a new transaction at the next IDLE.
//   - Masters deassert in the ack cycle for single accesses.
//  m_ack high in IDLE (stale): no grant issued until m_ack is low.
//  Reset mid-transaction: immediate return to reset values. The interpreter shares rst, so no handshake cleanup.
//  No timeout; a hung slave hangs the arbiter (watchdog lives upstream).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined
//   - Round-robin selection: search starts at pointer.
//   - Pointer <= winner+1 (mod NUM_REQ) when entering RELEASE.
//  ARB_ROUND_ROBIN_EN undefined
//   - Fixed priority: lowest active index wins; pointer register absent.
// STRUCTURE
//  mem_arb_pkg: state enum arb_state_t {IDLE, ISSUE, RELEASE}; NUM_REQ default; idx_t = logic [$clog2(NUM_REQ)-1:0].
//  Sub-module arb_picker: combinational.
//   - Inputs: active vector, pointer. Output: one-hot + index.
//   - Rotates only under ARB_ROUND_ROBIN_EN.
//  Top holds the FSM, latches and pointer.
// TESTING
//  1. Single read: req_ren[1]=1, addr 0x8000_0100, slave acks after 3 cycles with 0xDEAD_BEEF.
//     -> m_ren rises cycle+1; req_ack[1] pulses once; req_data_o = 0xDEADBEEF.
//  2. Contention, fixed priority: req 0 and 2 both read in the same cycle.
//     -> gnt = 001, then 100; req 2 acks only after m_ack has fallen.
//  3. Round-robin (macro on): all 3 hold requests for 6 transactions.
//     -> grant order 0,1,2,0,1,2; no requester acked twice in a row.
//  4. Write: req_wen[2]=1, addr 0x1F80_0010, data 0x1234_5678.
//     -> m_wen=1, m_data_i=0x12345678 stable until m_ack; ack pulse.
//  5. Handshake: slave holds m_ack high 4 cycles after m_ren drops, with a pending request.
//     -> no new m_ren/m_wen until m_ack=0.
//  6. Reset asserted during ISSUE.
//     -> m_ren, m_wen, gnt, req_ack all 0 same cycle; clean grant after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-bus arbiter slice.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IW-1:0] idx_t;
    typedef logic [1:0]    arb_state_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    // Round-robin successor with wrap at NUM_REQ
    function automatic idx_t next_idx(input idx_t i);
        return (32'(i) == NUM_REQ - 1) ? '0 : idx_t'(32'(i) + 32'd1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and interpreter-side bus bundle of the memory-bus arbiter.
interface mem_bus_arbiter_if;
    import mem_arb_pkg::*;

    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_ren;
    logic [NUM_REQ-1:0]    req_wen;
    logic [NUM_REQ-1:0]    req_ack;
    logic [DW-1:0]         req_data_o;
    logic [AW-1:0]         m_addr;
    logic [DW-1:0]         m_data_i;
    logic                  m_ren;
    logic                  m_wen;
    logic                  m_ack;
    logic [DW-1:0]         m_data_o;
    logic [NUM_REQ-1:0]    gnt;

    modport master (
        input  req_addr, req_data_i, req_ren, req_wen, m_ack, m_data_o,
        output req_ack, req_data_o, m_addr, m_data_i, m_ren, m_wen, gnt
    );

    modport slave (
        output req_addr, req_data_i, req_ren, req_wen, m_ack, m_data_o,
        input  req_ack, req_data_o, m_addr, m_data_i, m_ren, m_wen, gnt
    );

endinterface

// File: rtl/arb_picker.sv
// Combinational winner selection; rotates from i_ptr when ARB_ROUND_ROBIN_EN is defined,
// otherwise lowest active index wins.
module arb_picker
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_active,
`ifdef ARB_ROUND_ROBIN_EN
    input  idx_t               i_ptr,
`endif
    output logic [NUM_REQ-1:0] o_gnt_c,
    output idx_t               o_idx_c,
    output logic               o_any_c
);

    idx_t w_j;

    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        o_any_c = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_j = idx_t'((32'(i_ptr) + 32'(k)) % NUM_REQ);
`else
            w_j = idx_t'(k);
`endif
            if (!o_any_c && i_active[w_j]) begin
                o_any_c      = 1'b1;
                o_gnt_c[w_j] = 1'b1;
                o_idx_c      = w_j;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one ren/wen/ack memory port among NUM_REQ masters, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority otherwise.
module mem_bus_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);

    arb_state_t         r_state, w_state;
    logic [NUM_REQ-1:0] r_gnt,   w_gnt;
    logic [AW-1:0]      r_addr,  w_addr;
    logic [DW-1:0]      r_wdata, w_wdata;
    logic               r_ren,   w_ren;
    logic               r_wen,   w_wen;
    logic [NUM_REQ-1:0] r_ack,   w_ack;
    logic [DW-1:0]      r_rdata, w_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    idx_t               r_idx,   w_idx;
    idx_t               r_ptr,   w_ptr;
`endif

    logic [NUM_REQ-1:0] w_pick;
    idx_t               w_pick_idx;
    logic               w_any;

    arb_picker u_picker (
        .i_active (bus.req_ren | bus.req_wen),
`ifdef ARB_ROUND_ROBIN_EN
        .i_ptr    (r_ptr),
`endif
        .o_gnt_c  (w_pick),
        .o_idx_c  (w_pick_idx),
        .o_any_c  (w_any)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_ren   = r_ren;
        w_wen   = r_wen;
        w_ack   = '0;
        w_rdata = r_rdata;
`ifdef ARB_ROUND_ROBIN_EN
        w_idx   = r_idx;
        w_ptr   = r_ptr;
`endif
        case (r_state)
            IDLE: begin
                // A stale ack from the interpreter blocks any new grant
                if (w_any && !bus.m_ack) begin
                    w_state = ISSUE;
                    w_gnt   = w_pick;
                    w_addr  = bus.req_addr[32'(w_pick_idx)*AW +: AW];
                    w_wdata = bus.req_data_i[32'(w_pick_idx)*DW +: DW];
                    w_ren   = bus.req_ren[w_pick_idx];
                    w_wen   = bus.req_wen[w_pick_idx] & ~bus.req_ren[w_pick_idx];
`ifdef ARB_ROUND_ROBIN_EN
                    w_idx   = w_pick_idx;
`endif
                end
            end
            ISSUE: begin
                if (bus.m_ack) begin
                    w_state = RELEASE;
                    w_rdata = bus.m_data_o;
                    w_ack   = r_gnt;
                    w_ren   = 1'b0;
                    w_wen   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    w_ptr   = next_idx(r_idx);
`endif
                end
            end
            RELEASE: begin
                if (!bus.m_ack) begin
                    w_state = IDLE;
                    w_gnt   = '0;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_ack   <= '0;
            r_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_idx   <= '0;
            r_ptr   <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_ren   <= w_ren;
            r_wen   <= w_wen;
            r_ack   <= w_ack;
            r_rdata <= w_rdata;
`ifdef ARB_ROUND_ROBIN_EN
            r_idx   <= w_idx;
            r_ptr   <= w_ptr;
`endif
        end
    end

    assign bus.m_addr     = r_addr;
    assign bus.m_data_i   = r_wdata;
    assign bus.m_ren      = r_ren;
    assign bus.m_wen      = r_wen;
    assign bus.gnt        = r_gnt;
    assign bus.req_ack    = r_ack;
    assign bus.req_data_o = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural address-interpreter model.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t q[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   lat   = 3;
    int   hold  = 0;
    int   s_cnt = 0;
    int   s_hold = 0;
    int   rem[NUM_REQ];

    function automatic logic [DW-1:0] slv_data(input logic [AW-1:0] a);
        if (a == 32'h8000_0100) return 32'hDEAD_BEEF;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.idx   = i;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        e.rdata = slv_data(a);
        q.push_back(e);
    endtask

    task automatic drive(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input int n);
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_data_i[i*DW +: DW] = d;
        bus.req_ren[i]             = rd;
        bus.req_wen[i]             = wr;
        rem[i]                     = n;
    endtask

    task automatic clear_env();
        bus.req_ren    = '0;
        bus.req_wen    = '0;
        bus.req_addr   = '0;
        bus.req_data_i = '0;
        bus.m_ack      = 1'b0;
        bus.m_data_o   = '0;
        q.delete();
        s_cnt  = 0;
        s_hold = 0;
        hold   = 0;
        lat    = 3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_env();
        repeat (2) @(negedge clk);
        chk("rst_outs", 64'({bus.m_ren, bus.m_wen, bus.gnt, bus.req_ack}), 64'(0));
        chk("rst_rdata", 64'(bus.req_data_o), 64'(0));
        rst = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || bus.req_ren != '0 || bus.req_wen != '0 ||
                bus.gnt != '0 || bus.m_ack) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n >= budget), 64'(0));
    endtask

    // Address-interpreter model: ack after lat cycles, drop ack hold cycles after ren/wen fall
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                s_cnt  = 0;
                s_hold = 0;
            end else if (!bus.m_ack) begin
                if (bus.m_ren || bus.m_wen) begin
                    s_cnt++;
                    if (s_cnt >= lat) begin
                        if (q.size() != 0) begin
                            chk("m_addr", 64'(bus.m_addr), 64'(q[0].addr));
                            chk("gnt", 64'(bus.gnt), 64'(1 << q[0].idx));
                            chk("m_wen", 64'(bus.m_wen), 64'(q[0].wr));
                            chk("m_ren", 64'(bus.m_ren), 64'(!q[0].wr));
                            if (q[0].wr) chk("m_data_i", 64'(bus.m_data_i), 64'(q[0].wdata));
                        end
                        bus.m_data_o = slv_data(bus.m_addr);
                        bus.m_ack    = 1'b1;
                        s_cnt        = 0;
                        s_hold       = 0;
                    end
                end else begin
                    s_cnt = 0;
                end
            end else begin
                chk("issue_while_ack", 64'(bus.m_ren | bus.m_wen), 64'(0));
                if (!(bus.m_ren || bus.m_wen)) begin
                    if (s_hold >= hold) bus.m_ack = 1'b0;
                    else s_hold++;
                end
            end
        end
    end

    // Ack monitor and requester model: pops the scoreboard, drops requests when done
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.req_ack != '0) begin
                chk("ack_expected", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("ack_vec", 64'(bus.req_ack), 64'(1 << e.idx));
                    if (!e.wr) chk("rdata", 64'(bus.req_data_o), 64'(e.rdata));
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (bus.req_ack[i]) begin
                        rem[i]--;
                        if (rem[i] <= 0) begin
                            bus.req_ren[i] = 1'b0;
                            bus.req_wen[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_env();

        // Single read with latency check
        do_reset();
        drive(1, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 1);
        push(1, 1'b0, 32'h8000_0100, 32'h0);
        chk("t1_ren_pre", 64'(bus.m_ren), 64'(0));
        @(negedge clk);
        chk("t1_ren_rise", 64'(bus.m_ren), 64'(1));
        chk("t1_gnt", 64'(bus.gnt), 64'(3'b010));
        drain(200);
        chk("t1_rdata_hold", 64'(bus.req_data_o), 64'(32'hDEAD_BEEF));

        // Contention: 0 then 2
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1);
        drive(2, 1'b1, 1'b0, 32'h0000_0240, 32'h0, 1);
        push(0, 1'b0, 32'h0000_0040, 32'h0);
        push(2, 1'b0, 32'h0000_0240, 32'h0);
        drain(200);

        // All three hold requests for two transactions each
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            drive(i, 1'b1, 1'b0, 32'(32'h100 * i + 32'h44), 32'h0, 2);
`ifdef ARB_ROUND_ROBIN_EN
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                push(i, 1'b0, 32'(32'h100 * i + 32'h44), 32'h0);
`else
        for (int i = 0; i < NUM_REQ; i++)
            for (int r = 0; r < 2; r++)
                push(i, 1'b0, 32'(32'h100 * i + 32'h44), 32'h0);
`endif
        drain(400);

        // Write, then ren+wen together (read wins)
        do_reset();
        drive(2, 1'b0, 1'b1, 32'h1F80_0010, 32'h1234_5678, 1);
        push(2, 1'b1, 32'h1F80_0010, 32'h1234_5678);
        drain(200);
        drive(1, 1'b1, 1'b1, 32'h0000_2000, 32'hFFFF_0000, 1);
        push(1, 1'b0, 32'h0000_2000, 32'hFFFF_0000);
        drain(200);

        // Slave holds ack 4 cycles after ren drops, with a pending request
        do_reset();
        hold = 4;
        lat  = 2;
        drive(0, 1'b1, 1'b0, 32'h0000_0800, 32'h0, 1);
        drive(1, 1'b0, 1'b1, 32'h0000_0900, 32'hCAFE_F00D, 1);
        push(0, 1'b0, 32'h0000_0800, 32'h0);
        push(1, 1'b1, 32'h0000_0900, 32'hCAFE_F00D);
        drain(300);

        // Reset during ISSUE, then a clean grant
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h0000_0C00, 32'h0, 1);
        push(0, 1'b0, 32'h0000_0C00, 32'h0);
        repeat (2) @(negedge clk);
        chk("t6_in_issue", 64'(bus.m_ren), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", 64'({bus.m_ren, bus.m_wen, bus.gnt, bus.req_ack}), 64'(0));
        clear_env();
        @(negedge clk);
        rst = 1'b0;
        drive(2, 1'b1, 1'b0, 32'h0000_0D00, 32'h0, 1);
        push(2, 1'b0, 32'h0000_0D00, 32'h0);
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
